rom_sequencer: RTL

ROM_SEQUENCER -- requirements
Module: rom_sequencer

---
 rtl/seq_pkg.sv | 6 +
 rtl/contador_duracao.sv | 32 +++
 rtl/rom_sequencer.sv | 101 ++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// seq_pkg: state encoding and ROM constants shared by the sequencer and its bench.
package seq_pkg;
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, RUN, DONE} estado_t;
    localparam logic [7:0] TERMINADOR = 8'hFF;
    localparam logic [8:0] ULTIMO_END = 9'd511;
endpackage

// File: rtl/contador_duracao.sv
// contador_duracao: prescaler plus unit counter timing one RUN of Valor*PRESCALE cycles.
module contador_duracao #(
    parameter logic [15:0] PRESCALE = 16'd1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_carga,
    input  logic       i_en,
    input  logic [7:0] i_unidades,
    output logic       o_zero
);
    logic [7:0]  r_unid;
    logic [15:0] r_pre;
    // Flags the final cycle of the run so the FSM leaves RUN on the same edge.
    assign o_zero = (r_pre == 16'd0) && (r_unid <= 8'd1);
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_unid <= 8'd0;
            r_pre  <= 16'd0;
        end else if (i_carga) begin
            r_unid <= i_unidades;
            r_pre  <= PRESCALE - 16'd1;
        end else if (i_en) begin
            if (r_pre == 16'd0) begin
                r_pre  <= PRESCALE - 16'd1;
                r_unid <= r_unid - 8'd1;
            end else begin
                r_pre <= r_pre - 16'd1;
            end
        end
    end
endmodule

// File: rtl/rom_sequencer.sv
// rom_sequencer: walks a ROM table of durations, holding Ativo for each entry's
// Valor*PRESCALE cycles; 0 entries are skipped and 8'hFF ends the sequence.
module rom_sequencer
    import seq_pkg::*;
#(
    parameter logic [8:0]  BASE_ADDR = 9'd0,
    parameter logic [15:0] PRESCALE  = 16'd1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Iniciar,
    input  logic       Abortar,
    output logic [8:0] Endereco,
    input  logic [7:0] Dados,
    output logic [8:0] Passo,
    output logic [7:0] Valor,
    output logic       Ativo,
    output logic       Ocupado,
    output logic       Fim
);
    estado_t    r_estado, w_prox;
    logic [8:0] r_end, r_passo;
    logic [7:0] r_valor;
    logic       w_zero, w_carga, w_avanca, w_ultimo, w_inicio;

    assign w_ultimo = (r_end == ULTIMO_END);
    assign w_inicio = (r_estado == IDLE) && Iniciar;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_estado <= IDLE;
        else     r_estado <= w_prox;
    end

    always_comb begin
        w_prox   = r_estado;
        w_carga  = 1'b0;
        w_avanca = 1'b0;
        case (r_estado)
            IDLE:  w_prox = Iniciar ? FETCH : IDLE;
            FETCH: w_prox = LOAD;
            LOAD: begin
                if (Dados == TERMINADOR) begin
                    w_prox = DONE;
                end else if (Dados == 8'd0) begin
                    w_avanca = !w_ultimo;
                    w_prox   = w_ultimo ? DONE : FETCH;
                end else begin
                    w_carga = 1'b1;
                    w_prox  = RUN;
                end
            end
            RUN: begin
                if (w_zero) begin
                    w_avanca = !w_ultimo;
                    w_prox   = w_ultimo ? DONE : FETCH;
                end
            end
            DONE:    w_prox = IDLE;
            default: w_prox = IDLE;
        endcase
        // Abort overrides everything, including a pending load or address step.
        if (Abortar && (r_estado inside {FETCH, LOAD, RUN})) begin
            w_prox   = DONE;
            w_carga  = 1'b0;
            w_avanca = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_end   <= 9'd0;
            r_passo <= 9'd0;
            r_valor <= 8'd0;
        end else begin
            if (w_inicio) begin
                r_end   <= BASE_ADDR;
                r_passo <= 9'd0;
            end else if (w_avanca) begin
                r_end   <= r_end + 9'd1;
                r_passo <= r_passo + 9'd1;
            end
            if (w_carga) r_valor <= Dados;
        end
    end

    contador_duracao #(.PRESCALE(PRESCALE)) u_contador (
        .i_clk      (CLK),
        .i_rst      (RST),
        .i_carga    (w_carga),
        .i_en       (r_estado == RUN),
        .i_unidades (Dados),
        .o_zero     (w_zero)
    );

    assign Endereco = r_end;
    assign Passo    = r_passo;
    assign Valor    = r_valor;
    assign Ativo    = (r_estado == RUN);
    assign Ocupado  = (r_estado != IDLE);
    assign Fim      = (r_estado == DONE);
endmodule
